// File: rtl/softmax_pkg.sv
// Shared constants and state encoding for the softmax sequencer.
package softmax_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_INPUTS = 10;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXP     = 3'd1,
    ST_EXP_GAP = 3'd2,
    ST_REC     = 3'd3,
    ST_MUL     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/softmax_elem_buf.sv
// NUM_INPUTS x DATA_WIDTH register file: one parallel load port (whole
// vector at once), one single-element write port and one combinational
// read port. Load has priority over the element write.
module softmax_elem_buf
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int IDX_W      = $clog2(NUM_INPUTS + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] load_data,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [IDX_W-1:0]                 raddr,
  output logic [DATA_WIDTH-1:0]            rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_INPUTS];

  // Storage update: reset clears, load captures the full vector, else one element write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_INPUTS; i++) mem[i] <= load_data[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (we) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (waddr == IDX_W'(i)) mem[i] <= wdata;
      end
    end
  end

  // Read mux; out-of-range addresses return zero rather than an undefined entry.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (raddr == IDX_W'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/softmax_sequencer.sv
// Time-multiplexed softmax controller: one shared exponent unit, adder,
// reciprocal unit and multiplier are stepped over NUM_INPUTS elements.
//
// state    | meaning
// IDLE     | waiting for start; latches inputs when a run begins
// EXP      | exponent unit enabled on element idx; capture on exp_ack
// EXP_GAP  | one cycle with exp_enable low so the unit re-arms
// REC      | reciprocal of the accumulated sum; capture on rec_ack
// MUL      | one output element per cycle: exp_buf[idx] * rec_reg
// DONE     | results stable; wait for start to drop
module softmax_sequencer
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] inputs,
  output logic [DATA_WIDTH-1:0]            exp_x,
  output logic                             exp_enable,
  input  logic [DATA_WIDTH-1:0]            exp_out,
  input  logic                             exp_ack,
  output logic [DATA_WIDTH-1:0]            add_a,
  output logic [DATA_WIDTH-1:0]            add_b,
  input  logic [DATA_WIDTH-1:0]            add_sum,
  output logic [DATA_WIDTH-1:0]            rec_in,
  output logic                             rec_enable,
  input  logic [DATA_WIDTH-1:0]            rec_out,
  input  logic                             rec_ack,
  output logic [DATA_WIDTH-1:0]            mul_a,
  output logic [DATA_WIDTH-1:0]            mul_b,
  input  logic [DATA_WIDTH-1:0]            mul_out,
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] outputs,
  output logic                             busy,
  output logic                             done
);

  localparam int IDX_W = $clog2(NUM_INPUTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [DATA_WIDTH-1:0] SUM_INIT = DATA_WIDTH'(FP_ZERO);

  state_t                state, state_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] sum_reg, sum_next;
  logic [DATA_WIDTH-1:0] rec_reg, rec_next;
  logic                  in_load, exp_we, out_we;
  logic [DATA_WIDTH-1:0] in_rdata, exp_rdata;

  softmax_elem_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (in_load),
    .load_data (inputs),
    .we        (1'b0),
    .waddr     ('0),
    .wdata     ('0),
    .raddr     (idx),
    .rdata     (in_rdata)
  );

  softmax_elem_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_exp_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .we        (exp_we),
    .waddr     (idx),
    .wdata     (exp_out),
    .raddr     (idx),
    .rdata     (exp_rdata)
  );

  // State, index and scalar accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      sum_reg <= SUM_INIT;
      rec_reg <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      sum_reg <= sum_next;
      rec_reg <= rec_next;
    end
  end

  // Result vector: one element per MUL cycle; values persist across aborts.
  always_ff @(posedge clk) begin
    if (reset) begin
      outputs <= '0;
    end else if (out_we) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (idx == IDX_W'(i)) outputs[i*DATA_WIDTH +: DATA_WIDTH] <= mul_out;
      end
    end
  end

  // Next-state and unit handshakes. Dropping start in a busy state aborts to
  // IDLE and takes priority over any ack arriving in the same cycle.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    sum_next   = sum_reg;
    rec_next   = rec_reg;
    in_load    = 1'b0;
    exp_we     = 1'b0;
    out_we     = 1'b0;
    exp_enable = 1'b0;
    rec_enable = 1'b0;
    exp_x      = '0;
    add_a      = '0;
    add_b      = '0;
    rec_in     = '0;
    mul_a      = '0;
    mul_b      = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          in_load    = 1'b1;
          idx_next   = '0;
          sum_next   = SUM_INIT;
          state_next = ST_EXP;
        end
      end
      ST_EXP: begin
        exp_enable = 1'b1;
        exp_x      = in_rdata;
        add_a      = exp_out;
        add_b      = sum_reg;
        if (!start) begin
          state_next = ST_IDLE;
        end else if (exp_ack) begin
          exp_we     = 1'b1;
          sum_next   = add_sum;
          state_next = ST_EXP_GAP;
        end
      end
      ST_EXP_GAP: begin
        if (!start) begin
          state_next = ST_IDLE;
        end else if (idx == LAST_IDX) begin
          state_next = ST_REC;
        end else begin
          idx_next   = idx + IDX_W'(1);
          state_next = ST_EXP;
        end
      end
      ST_REC: begin
        rec_enable = 1'b1;
        rec_in     = sum_reg;
        if (!start) begin
          state_next = ST_IDLE;
        end else if (rec_ack) begin
          rec_next   = rec_out;
          idx_next   = '0;
          state_next = ST_MUL;
        end
      end
      ST_MUL: begin
        mul_a = exp_rdata;
        mul_b = rec_reg;
        if (!start) begin
          state_next = ST_IDLE;
        end else begin
          out_we = 1'b1;
          if (idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start) state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_softmax_sequencer.sv
// Bench for softmax_sequencer: behavioural arithmetic-unit models with
// configurable handshake latency, and a reference softmax composition.
module tb_softmax_sequencer;
  import softmax_pkg::*;

  localparam int DW = 32;
  localparam int N  = 10;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [DW*N-1:0] inputs, outputs;
  logic [DW-1:0]   exp_x, exp_out, add_a, add_b, add_sum;
  logic [DW-1:0]   rec_in, rec_out, mul_a, mul_b, mul_out;
  logic            exp_enable, exp_ack, rec_enable, rec_ack, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  int le = 4, lr = 6;
  int exp_cnt = 0, rec_cnt = 0;
  bit float_mode = 1'b0;
  bit force_exp_ack = 1'b0, force_rec_ack = 1'b0;
  logic [DW-1:0] rec_seen;

  always #5 clk = ~clk;

  softmax_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .inputs(inputs),
    .exp_x(exp_x), .exp_enable(exp_enable), .exp_out(exp_out), .exp_ack(exp_ack),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rec_in(rec_in), .rec_enable(rec_enable), .rec_out(rec_out), .rec_ack(rec_ack),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .outputs(outputs), .busy(busy), .done(done)
  );

  // ---------------- float helpers (round half up) ----------------
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [30:0] m;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    m = {8'(int'(d[62:52]) - 1023 + 127), d[51:29]} + 31'(d[28]);
    return {d[63], m};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // ---------------- integer "units" for exact randomized checking ----------------
  function automatic logic [31:0] h_exp(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h9E37_79B9;
  endfunction
  function automatic logic [31:0] h_add(input logic [31:0] a, input logic [31:0] b);
    return a + b * 32'd3;
  endfunction
  function automatic logic [31:0] h_rec(input logic [31:0] x);
    return ~x ^ 32'h0F0F_1234;
  endfunction
  function automatic logic [31:0] h_mul(input logic [31:0] a, input logic [31:0] b);
    return a * 32'd3 + b;
  endfunction

  // Reference: e_i = exp(x_i); s = sum of e_i in index order; r = 1/s; y_i = e_i * r.
  function automatic logic [DW*N-1:0] ref_model(input logic [DW*N-1:0] v);
    logic [31:0] e [N];
    logic [31:0] s, r;
    logic [DW*N-1:0] y;
    s = 32'd0;
    for (int i = 0; i < N; i++) begin
      e[i] = h_exp(v[i*DW +: DW]);
      s = h_add(e[i], s);
    end
    r = h_rec(s);
    for (int i = 0; i < N; i++) y[i*DW +: DW] = h_mul(e[i], r);
    return y;
  endfunction

  function automatic logic [DW*N-1:0] rand_vec();
    logic [DW*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom();
    return v;
  endfunction

  // Unit latency models: ack rises Le (Lr) cycles after enable rises; reset while enable low.
  always @(posedge clk) begin
    if (!exp_enable) exp_cnt <= 0;
    else if (exp_cnt < le) exp_cnt <= exp_cnt + 1;
    if (!rec_enable) rec_cnt <= 0;
    else if (rec_cnt < lr) rec_cnt <= rec_cnt + 1;
  end

  always_comb begin
    exp_ack = (exp_enable && exp_cnt == le) || (force_exp_ack && !exp_enable);
    rec_ack = (rec_enable && rec_cnt == lr) || (force_rec_ack && !rec_enable);
    if (float_mode) begin
      exp_out = r2f($exp(f2r(exp_x)));
      add_sum = r2f(f2r(add_a) + f2r(add_b));
      rec_out = (f2r(rec_in) == 0.0) ? 32'd0 : r2f(1.0 / f2r(rec_in));
      mul_out = r2f(f2r(mul_a) * f2r(mul_b));
    end else begin
      exp_out = h_exp(exp_x);
      add_sum = h_add(add_a, add_b);
      rec_out = h_rec(rec_in);
      mul_out = h_mul(mul_a, mul_b);
    end
  end

  // Raise start and step until done (or budget). First counted edge is the start-sampled edge.
  task automatic run(input int budget, input bit scramble, output int cycles, output bit got_done);
    start = 1'b1;
    cycles = 0;
    got_done = 1'b0;
    while (!got_done && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (scramble && cycles == 1) inputs = rand_vec();
      if (rec_enable) rec_seen = rec_in;
      if (done) got_done = 1'b1;
    end
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inputs = rand_vec();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if ({exp_enable, rec_enable} !== 2'b00) begin n_bad++; $display("FAIL reset_enables got=%b want=00", {exp_enable, rec_enable}); end
    n_cmp++; if (outputs !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h want=0", outputs); end
    n_cmp++; if ({exp_x, add_a, add_b, rec_in, mul_a, mul_b} !== '0) begin
      n_bad++; $display("FAIL reset_operands got=%h want=0", {exp_x, add_a, add_b, rec_in, mul_a, mul_b});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_float_ones();
    int cyc; bit ok; logic [31:0] want;
    float_mode = 1'b1; le = 4; lr = 6;
    inputs = '0;
    run(2000, 1'b0, cyc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ones_timeout got=no_done want=done"); end
    n_cmp++; if (cyc != 78) begin n_bad++; $display("FAIL ones_latency got=%0d want=78", cyc); end
    n_cmp++; if (rec_seen !== 32'h4120_0000) begin n_bad++; $display("FAIL ones_rec_in got=%h want=41200000", rec_seen); end
    want = r2f(f2r(FP_ONE) * f2r(r2f(1.0 / 10.0)));
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (outputs[i*DW +: DW] !== want) begin
        n_bad++; $display("FAIL ones_out[%0d] got=%h want=%h", i, outputs[i*DW +: DW], want);
      end
    end
    drop_start();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ones_done_clear got=%b want=0", done); end
  endtask

  task automatic test_float_onehot();
    int cyc; bit ok; int diff; real e, got, want;
    float_mode = 1'b1; le = 3; lr = 2;
    inputs = '0;
    inputs[3*DW +: DW] = FP_ONE;
    run(2000, 1'b0, cyc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL onehot_timeout got=no_done want=done"); end
    diff = int'(rec_seen) - int'(32'h413B_7E15);
    n_cmp++; if (diff > 1 || diff < -1) begin n_bad++; $display("FAIL onehot_sum got=%h want=413b7e15+-1", rec_seen); end
    e = $exp(1.0);
    for (int i = 0; i < N; i++) begin
      got  = f2r(outputs[i*DW +: DW]);
      want = ((i == 3) ? e : 1.0) / (e + 9.0);
      n_cmp++;
      if (got - want > 1.0e-5 || want - got > 1.0e-5) begin
        n_bad++; $display("FAIL onehot_out[%0d] got=%f want=%f", i, got, want);
      end
    end
    n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL onehot_flags got=%b want=10", {done, busy}); end
    drop_start();
    float_mode = 1'b0;
  endtask

  task automatic test_random();
    int cyc; bit ok; logic [DW*N-1:0] v, want;
    float_mode = 1'b0;
    for (int r = 0; r < 4; r++) begin
      le = $urandom_range(1, 5); lr = $urandom_range(1, 5);
      v = rand_vec(); inputs = v; want = ref_model(v);
      run(3000, 1'b1, cyc, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_timeout got=no_done want=done", r); end
      n_cmp++;
      if (cyc != N*(le+2) + lr + 1 + N + 1) begin
        n_bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", r, cyc, N*(le+2) + lr + 1 + N + 1);
      end
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (outputs[i*DW +: DW] !== want[i*DW +: DW]) begin
          n_bad++; $display("FAIL rand%0d_out[%0d] got=%h want=%h", r, i, outputs[i*DW +: DW], want[i*DW +: DW]);
        end
      end
      drop_start();
    end
  endtask

  task automatic test_abort();
    int cyc, rises, guard; bit ok, prev; logic [DW*N-1:0] v, want;
    le = 2; lr = 3;
    v = rand_vec(); inputs = v; want = ref_model(v);
    start = 1'b1; rises = 0; prev = 1'b0; guard = 0;
    while (rises < 6 && guard < 500) begin
      @(posedge clk); #1; guard++;
      if (exp_enable && !prev) rises++;
      prev = exp_enable;
    end
    n_cmp++; if (rises != 6) begin n_bad++; $display("FAIL abort_reach_idx5 got=%0d want=6", rises); end
    start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({busy, exp_enable, done} !== 3'b000) begin
      n_bad++; $display("FAIL abort_state got=%b want=000", {busy, exp_enable, done});
    end
    run(3000, 1'b0, cyc, ok);
    n_cmp++; if (!ok || cyc != N*(le+2) + lr + 1 + N + 1) begin
      n_bad++; $display("FAIL abort_restart_latency got=%0d want=%0d", cyc, N*(le+2) + lr + 1 + N + 1);
    end
    n_cmp++; if (outputs !== want) begin n_bad++; $display("FAIL abort_restart_out got=%h want=%h", outputs, want); end
    drop_start();
  endtask

  task automatic test_reset_mid_mul();
    int guard; bit prev; logic [DW*N-1:0] v, want;
    le = 1; lr = 2;
    v = rand_vec(); inputs = v; want = ref_model(v);
    start = 1'b1; prev = 1'b0; guard = 0;
    while (!(prev && !rec_enable && busy) && guard < 500) begin
      prev = rec_enable;
      @(posedge clk); #1; guard++;
    end
    n_cmp++; if (guard >= 500) begin n_bad++; $display("FAIL mulrst_reach_mul got=timeout want=mul"); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (outputs[3*DW +: DW] !== want[3*DW +: DW]) begin
      n_bad++; $display("FAIL mulrst_partial got=%h want=%h", outputs[3*DW +: DW], want[3*DW +: DW]);
    end
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (outputs !== '0) begin n_bad++; $display("FAIL mulrst_outputs got=%h want=0", outputs); end
    n_cmp++; if ({done, busy, exp_enable, rec_enable} !== 4'b0000) begin
      n_bad++; $display("FAIL mulrst_flags got=%b want=0000", {done, busy, exp_enable, rec_enable});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_spurious();
    int cyc; bit ok; logic [DW*N-1:0] snap, v, want;
    le = 3; lr = 4;
    start = 1'b0; snap = outputs;
    force_exp_ack = 1'b1; force_rec_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || outputs !== snap) begin
      n_bad++; $display("FAIL spur_idle got=busy%b want=busy0_unchanged", busy);
    end
    v = rand_vec(); inputs = v; want = ref_model(v);
    run(3000, 1'b0, cyc, ok);
    n_cmp++; if (!ok || cyc != N*(le+2) + lr + 1 + N + 1) begin
      n_bad++; $display("FAIL spur_latency got=%0d want=%0d", cyc, N*(le+2) + lr + 1 + N + 1);
    end
    n_cmp++; if (outputs !== want) begin n_bad++; $display("FAIL spur_out got=%h want=%h", outputs, want); end
    force_exp_ack = 1'b0; force_rec_ack = 1'b0;
    drop_start();
  endtask

  task automatic test_hold_start();
    int cyc; bit ok; logic [DW*N-1:0] v, want;
    le = 2; lr = 1;
    v = rand_vec(); inputs = v;
    run(3000, 1'b0, cyc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hold_first_timeout got=no_done want=done"); end
    inputs = rand_vec();
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if ({done, busy, exp_enable} !== 3'b100) begin
      n_bad++; $display("FAIL hold_stay_done got=%b want=100", {done, busy, exp_enable});
    end
    n_cmp++; if (outputs !== ref_model(v)) begin n_bad++; $display("FAIL hold_no_rerun got=%h want=%h", outputs, ref_model(v)); end
    v = rand_vec(); inputs = v; want = ref_model(v);
    start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL hold_drop_done got=%b want=0", done); end
    run(3000, 1'b0, cyc, ok);
    n_cmp++; if (!ok || cyc != N*(le+2) + lr + 1 + N + 1) begin
      n_bad++; $display("FAIL hold_second_latency got=%0d want=%0d", cyc, N*(le+2) + lr + 1 + N + 1);
    end
    n_cmp++; if (outputs !== want) begin n_bad++; $display("FAIL hold_second_out got=%h want=%h", outputs, want); end
    drop_start();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; inputs = '0;
    test_reset();
    test_float_ones();
    test_float_onehot();
    test_random();
    test_abort();
    test_reset_mid_mul();
    test_spurious();
    test_hold_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
